bus_cycle_controller: RTL and testbench

Parametrised 68030 bus-cycle controller that generalises the system controller's fixed address decode into table-driven regions.
- Decodes NUM_REGIONS regions from the high address bits and drives a registered chip select per region.
- Generates DSACK0_n/DSACK1_n by port size, after a per-region wait count or after an external device ready.
- Adds a bus-timeout watchdog that drives BERR_n, and a parametrised boot overlay that maps the boot region at all addresses for the first BOOT_CYCLES bus cycles.
- Sits between the CPU bus and the memory/peripheral chip selects on the system CPLD.

---
 rtl/bus_cycle_pkg.sv | 20 ++
 rtl/region_decoder.sv | 36 +++
 rtl/bus_cycle_controller.sv | 152 +++++++++++++++
 tb/tb_bus_cycle_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_pkg.sv
// Shared types and helpers for the 68030 bus-cycle controller.
package bus_cycle_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  localparam logic [1:0] PORT_32 = 2'b00;
  localparam logic [1:0] PORT_8  = 2'b01;
  localparam logic [1:0] PORT_16 = 2'b10;

  // Returns {DSACK1_n, DSACK0_n}; the reserved encoding answers as a 32-bit port.
  function automatic logic [1:0] port_to_dsack(input logic [1:0] port);
    case (port)
      PORT_32: return 2'b00;
      PORT_8:  return 2'b10;
      PORT_16: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/region_decoder.sv
// Table-driven address decode; lowest matching region wins, overlay forces the boot region.
module region_decoder
  import bus_cycle_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned DECODE_BITS = 8,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned BOOT_REGION = 0,
  parameter logic [NUM_REGIONS*DECODE_BITS-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*DECODE_BITS-1:0] REGION_MASK = '0
) (
  input  logic [DECODE_BITS-1:0] a_hi,
  input  logic                   overlay,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    if (overlay) begin
      hit = 1'b1;
      idx = IDX_W'(BOOT_REGION);
    end else begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        if (!hit && ((a_hi & REGION_MASK[i*DECODE_BITS +: DECODE_BITS]) ==
                     (REGION_BASE[i*DECODE_BITS +: DECODE_BITS] &
                      REGION_MASK[i*DECODE_BITS +: DECODE_BITS]))) begin
          hit = 1'b1;
          idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// 68030 bus-cycle controller: region chip selects, sized DSACK, timeout BERR, boot overlay.
module bus_cycle_controller
  import bus_cycle_pkg::*;
#(
  parameter int unsigned NUM_REGIONS    = 4,
  parameter int unsigned DECODE_BITS    = 8,
  parameter logic [NUM_REGIONS*DECODE_BITS-1:0] REGION_BASE = {8'hF0, 8'hC0, 8'h00, 8'h80},
  parameter logic [NUM_REGIONS*DECODE_BITS-1:0] REGION_MASK = {8'hFF, 8'hF0, 8'hF0, 8'hF0},
  parameter int unsigned WAIT_W         = 4,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {4'd1, 4'd0, 4'd0, 4'd2},
  parameter logic [NUM_REGIONS*2-1:0] REGION_PORT = {2'b01, 2'b00, 2'b00, 2'b01},
  parameter logic [NUM_REGIONS-1:0] REGION_EXT = 4'b1100,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned BOOT_CYCLES    = 8,
  parameter int unsigned BOOT_REGION    = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DECODE_BITS-1:0] A_HI,
  input  logic [2:0]             FC,
  input  logic                   AS_n,
  input  logic [NUM_REGIONS-1:0] EXT_ACK_n,
  output logic [NUM_REGIONS-1:0] CS_n,
  output logic                   DSACK0_n,
  output logic                   DSACK1_n,
  output logic                   BERR_n,
  output logic                   BOOT
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BC_W  = $clog2(BOOT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BC_W-1:0] BOOT_LAST = BC_W'(BOOT_CYCLES - 1);

  generate
    if (TIMEOUT_CYCLES <= (2 ** WAIT_W) || BOOT_CYCLES == 0) begin : g_param_check
      $error("bus_cycle_controller: TIMEOUT_CYCLES must exceed 2**WAIT_W and BOOT_CYCLES must be nonzero");
    end
  endgenerate

  state_t                   state, state_nx;
  logic                     hit_q;
  logic [IDX_W-1:0]         idx_q;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [TO_W-1:0]          to_cnt;
  logic [BC_W-1:0]          boot_cnt;
  logic                     boot_q;
  logic [NUM_REGIONS-1:0]   cs_q, cs_nx;
  logic [1:0]               dsack_q, dsack_nx;
  logic                     berr_q, berr_nx;

  logic                     dec_hit;
  logic [IDX_W-1:0]         dec_idx;
  logic [WAIT_W-1:0]        dec_wait;
  logic                     start, ack_ok;

  region_decoder #(
    .NUM_REGIONS (NUM_REGIONS),
    .DECODE_BITS (DECODE_BITS),
    .IDX_W       (IDX_W),
    .BOOT_REGION (BOOT_REGION),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_region_decoder (
    .a_hi    (A_HI),
    .overlay (!boot_q),
    .hit     (dec_hit),
    .idx     (dec_idx)
  );

  assign dec_wait = REGION_WAIT[dec_idx*WAIT_W +: WAIT_W];
  assign start    = (state == IDLE) && !AS_n && (FC != 3'b111);
  // A cycle with no region hit can only end by timeout or abort.
  assign ack_ok   = hit_q && (wait_cnt == '0) && (!REGION_EXT[idx_q] || !EXT_ACK_n[idx_q]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      wait_cnt <= '0;
      to_cnt   <= '0;
      boot_cnt <= '0;
      boot_q   <= 1'b0;
      cs_q     <= '1;
      dsack_q  <= 2'b11;
      berr_q   <= 1'b1;
    end else begin
      state   <= state_nx;
      cs_q    <= cs_nx;
      dsack_q <= dsack_nx;
      berr_q  <= berr_nx;
      if (start) begin
        hit_q    <= dec_hit;
        idx_q    <= dec_idx;
        wait_cnt <= dec_wait;
        to_cnt   <= '0;
        if (!boot_q) begin
          boot_cnt <= boot_cnt + 1'b1;
          if (boot_cnt == BOOT_LAST) boot_q <= 1'b1;
        end
      end else if (state == WAIT) begin
        if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = WAIT;
      WAIT: begin
        if (AS_n)                   state_nx = IDLE;
        else if (ack_ok)            state_nx = ACK;
        else if (to_cnt == TO_LAST) state_nx = ERR;
      end
      ACK:     if (AS_n) state_nx = IDLE;
      ERR:     if (AS_n) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    cs_nx    = cs_q;
    dsack_nx = dsack_q;
    berr_nx  = berr_q;
    if (state != IDLE && AS_n) begin
      cs_nx    = '1;
      dsack_nx = 2'b11;
      berr_nx  = 1'b1;
    end else if (start) begin
      cs_nx    = '1;
      dsack_nx = 2'b11;
      berr_nx  = 1'b1;
      if (dec_hit) cs_nx[dec_idx] = 1'b0;
    end else if (state == WAIT && state_nx == ACK) begin
      dsack_nx = port_to_dsack(REGION_PORT[idx_q*2 +: 2]);
    end else if (state == WAIT && state_nx == ERR) begin
      berr_nx = 1'b0;
    end
  end

  assign CS_n     = cs_q;
  assign DSACK1_n = dsack_q[1];
  assign DSACK0_n = dsack_q[0];
  assign BERR_n   = berr_q;
  assign BOOT     = boot_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller with a transaction-level reference model.
module tb_bus_cycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_hi = 8'h00;
  logic [2:0] fc = 3'b101;
  logic       as_n = 1'b1;
  logic [3:0] ext_ack_n = 4'hF;
  logic [3:0] cs_n;
  logic       dsack0_n, dsack1_n, berr_n, boot;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_cycle_controller #(
    .NUM_REGIONS    (4),
    .DECODE_BITS    (8),
    .TIMEOUT_CYCLES (64),
    .BOOT_CYCLES    (8),
    .BOOT_REGION    (0)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .A_HI      (a_hi),
    .FC        (fc),
    .AS_n      (as_n),
    .EXT_ACK_n (ext_ack_n),
    .CS_n      (cs_n),
    .DSACK0_n  (dsack0_n),
    .DSACK1_n  (dsack1_n),
    .BERR_n    (berr_n),
    .BOOT      (boot)
  );

  // Region table as seen by the CPU: index 0..3.
  logic [7:0] m_base [4] = '{8'h80, 8'h00, 8'hC0, 8'hF0};
  logic [7:0] m_mask [4] = '{8'hF0, 8'hF0, 8'hF0, 8'hFF};
  int         m_wait [4] = '{2, 0, 0, 1};
  bit         m_ext  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] m_ack  [4] = '{2'b10, 2'b00, 2'b00, 2'b10};

  function automatic int lookup(logic [7:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  logic [3:0] exp_cs = 4'hF;
  logic [1:0] exp_dsack = 2'b11;
  logic       exp_berr = 1'b1;
  logic       exp_boot = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_region = -1;
  int         m_elapsed = 0;
  int         m_boots = 0;

  // Reference model: tracks each bus cycle by edges elapsed since it started.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_cs = 4'hF; exp_dsack = 2'b11; exp_berr = 1'b1;
      m_boots = 0; m_busy = 1'b0; m_valid = 1'b1;
    end else if (!m_busy) begin
      if (!as_n && fc != 3'b111) begin
        m_region = (m_boots < 8) ? 0 : lookup(a_hi);
        if (m_boots < 8) m_boots++;
        m_busy = 1'b1; m_done = 1'b0; m_elapsed = 0;
        exp_cs = 4'hF; exp_dsack = 2'b11; exp_berr = 1'b1;
        if (m_region >= 0) exp_cs[m_region] = 1'b0;
      end
    end else if (as_n) begin
      m_busy = 1'b0;
      exp_cs = 4'hF; exp_dsack = 2'b11; exp_berr = 1'b1;
    end else if (!m_done) begin
      m_elapsed++;
      if (m_region >= 0 && m_elapsed > m_wait[m_region] &&
          (!m_ext[m_region] || !ext_ack_n[m_region])) begin
        exp_dsack = m_ack[m_region];
        m_done = 1'b1;
      end else if (m_elapsed == 64) begin
        exp_berr = 1'b0;
        m_done = 1'b1;
      end
    end
    exp_boot = (m_boots >= 8);
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      checks++;
      if ({cs_n, dsack1_n, dsack0_n, berr_n, boot} !== {exp_cs, exp_dsack, exp_berr, exp_boot}) begin
        failures++;
        $display("FAIL model t=%0t actual cs=%b ds=%b%b berr=%b boot=%b required cs=%b ds=%b berr=%b boot=%b",
                 $time, cs_n, dsack1_n, dsack0_n, berr_n, boot, exp_cs, exp_dsack, exp_berr, exp_boot);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(logic [7:0] a);
    a_hi = a;
    as_n = 1'b0;
  endtask

  task automatic stop();
    as_n = 1'b1;
    tick(2);
  endtask

  task automatic lit(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    tick(2);
    lit("reset", {cs_n, dsack1_n, dsack0_n, berr_n, boot}, 8'b1111_1110);
    rst = 1'b0;
    tick(1);

    for (int i = 0; i < 8; i++) begin
      start(8'h00);
      tick(1);
      lit("boot_cs", {4'h0, cs_n}, 8'h0E);
      lit("boot_flag", {7'h0, boot}, (i == 7) ? 8'h01 : 8'h00);
      tick(2);
      lit("boot_wait", {6'h0, dsack1_n, dsack0_n}, 8'h03);
      tick(1);
      lit("boot_ack", {6'h0, dsack1_n, dsack0_n}, 8'h02);
      stop();
    end

    start(8'h00);
    tick(1);
    lit("post_boot_cs", {4'h0, cs_n}, 8'h0D);
    lit("post_boot_wait", {6'h0, dsack1_n, dsack0_n}, 8'h03);
    tick(1);
    lit("post_boot_ack", {6'h0, dsack1_n, dsack0_n}, 8'h00);
    stop();

    start(8'hF0);
    tick(10);
    lit("ext3_cs", {4'h0, cs_n}, 8'h07);
    lit("ext3_wait", {6'h0, dsack1_n, dsack0_n}, 8'h03);
    ext_ack_n = 4'b0111;
    tick(1);
    lit("ext3_ack", {6'h0, dsack1_n, dsack0_n}, 8'h02);
    lit("ext3_berr", {7'h0, berr_n}, 8'h01);
    lit("ext3_cs_hold", {4'h0, cs_n}, 8'h07);
    stop();
    ext_ack_n = 4'hF;

    start(8'h40);
    tick(64);
    lit("nohit_pre", {4'h0, cs_n[3:0] & 4'hF}, 8'h0F);
    lit("nohit_berr_pre", {7'h0, berr_n}, 8'h01);
    tick(1);
    lit("nohit_berr", {7'h0, berr_n}, 8'h00);
    as_n = 1'b1;
    tick(1);
    lit("nohit_release", {4'h0, cs_n, berr_n, 3'b000}, 8'hF8);
    tick(1);

    start(8'hC0);
    tick(64);
    ext_ack_n = 4'b1011;
    tick(1);
    lit("ext2_tie_ack", {6'h0, dsack1_n, dsack0_n}, 8'h00);
    lit("ext2_tie_berr", {7'h0, berr_n}, 8'h01);
    stop();
    ext_ack_n = 4'hF;

    fc = 3'b111;
    start(8'h80);
    tick(100);
    lit("cpu_space", {cs_n, dsack1_n, dsack0_n, berr_n, boot}, 8'b1111_1111);
    as_n = 1'b1;
    fc = 3'b101;
    tick(1);

    start(8'h80);
    tick(2);
    lit("abort_cs", {4'h0, cs_n}, 8'h0E);
    as_n = 1'b1;
    tick(1);
    lit("abort_idle", {4'h0, cs_n}, 8'h0F);
    tick(3);
    lit("abort_no_ack", {6'h0, dsack1_n, dsack0_n}, 8'h03);

    start(8'h80);
    tick(1);
    rst = 1'b1;
    tick(1);
    lit("mid_reset", {cs_n, dsack1_n, dsack0_n, berr_n, boot}, 8'b1111_1110);
    rst = 1'b0;
    as_n = 1'b1;
    tick(1);
    start(8'hF0);
    tick(1);
    lit("rearm_cs", {4'h0, cs_n}, 8'h0E);
    tick(3);
    lit("rearm_ack", {6'h0, dsack1_n, dsack0_n}, 8'h02);
    stop();

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
